// File: rtl/csi2_pixel_axis_adapter.sv
// Converts CSI-2 decoder pixel/line/frame strobes into an AXI4-Stream video stream (TUSER = SOF, TLAST = EOL).
// Define CSI2_FRAME_STATS_EN to measure frame geometry on LINE_WIDTH_O / FRAME_HEIGHT_O.
module csi2_pixel_axis_adapter #(
  parameter int unsigned g_DATAWIDTH = 10,
  parameter int unsigned g_FIFO_AW   = 10
) (
  input  logic                   PARALLEL_CLOCK_I,
  input  logic                   RESET_I,
  input  logic                   FRAME_START_I,
  input  logic                   FRAME_END_I,
  input  logic                   LINE_VALID_I,
  input  logic [g_DATAWIDTH-1:0] DATA_I,
  input  logic                   ECC_ERROR_I,
  input  logic                   CRC_ERROR_I,
  input  logic                   CLEAR_I,
  output logic [g_DATAWIDTH-1:0] TDATA_O,
  output logic                   TVALID_O,
  input  logic                   TREADY_I,
  output logic                   TUSER_O,
  output logic                   TLAST_O,
  output logic                   OVERFLOW_O,
  output logic [15:0]            ERR_COUNT_O,
  output logic [15:0]            LINE_WIDTH_O,
  output logic [15:0]            FRAME_HEIGHT_O
);

  localparam int unsigned W_ENT = g_DATAWIDTH + 2;
  localparam int unsigned DEPTH = 1 << g_FIFO_AW;
  localparam int unsigned W_CNT = g_FIFO_AW + 1;
  localparam logic [15:0] C_SAT = 16'hFFFF;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DROP} state_t;

  state_t                   r_state;
  state_t                   w_nstate;
  logic                     r_lv_q;
  logic                     r_hold_vld;
  logic                     r_hold_sof;
  logic [g_DATAWIDTH-1:0]   r_hold_data;
  logic                     r_sof_pending;
  logic [W_ENT-1:0]         r_mem [DEPTH];
  logic [g_FIFO_AW-1:0]     r_wr_ptr;
  logic [g_FIFO_AW-1:0]     r_rd_ptr;
  logic [W_CNT-1:0]         r_count;
  logic                     r_out_vld;
  logic [W_ENT-1:0]         r_out_ent;
  logic                     r_overflow;
  logic [15:0]              r_err_cnt;

  logic                     w_fall;
  logic                     w_full;
  logic                     w_push_req;
  logic                     w_push_last;
  logic                     w_push;
  logic                     w_drop;
  logic                     w_hold_load;
  logic                     w_hold_clr;
  logic                     w_sof_set;
  logic [W_ENT-1:0]         w_push_ent;
  logic [W_CNT-1:0]         w_mcount;
  logic                     w_mem_empty;
  logic                     w_out_load;
  logic                     w_pop_mem;
  logic                     w_mem_wr;
  logic                     w_beat;

  assign w_fall     = r_lv_q && !LINE_VALID_I;
  assign w_full     = (r_count == W_CNT'(DEPTH));
  assign w_push     = w_push_req && !w_full;
  assign w_push_ent = {r_hold_sof, w_push_last, r_hold_data};

  // FSM state register
  always_ff @(posedge PARALLEL_CLOCK_I or posedge RESET_I) begin
    if (RESET_I) r_state <= S_IDLE;
    else         r_state <= w_nstate;
  end

  // Next state and hold-register push decisions; at most one push per cycle
  always_comb begin
    w_nstate    = r_state;
    w_push_req  = 1'b0;
    w_push_last = 1'b0;
    w_hold_load = 1'b0;
    w_hold_clr  = 1'b0;
    w_sof_set   = 1'b0;
    w_drop      = 1'b0;
    if (FRAME_START_I) begin
      w_nstate    = S_ACTIVE;
      w_push_req  = r_hold_vld;
      w_push_last = 1'b1;
      w_hold_clr  = 1'b1;
      w_sof_set   = 1'b1;
    end else if (FRAME_END_I) begin
      w_nstate    = S_IDLE;
      w_push_req  = r_hold_vld;
      w_push_last = 1'b1;
      w_hold_clr  = 1'b1;
    end else begin
      case (r_state)
        S_ACTIVE: begin
          if (LINE_VALID_I) begin
            w_push_req  = r_hold_vld;
            w_hold_load = 1'b1;
          end else if (w_fall) begin
            w_push_req  = r_hold_vld;
            w_push_last = 1'b1;
            w_hold_clr  = 1'b1;
          end
        end
        default: w_hold_clr = 1'b1;
      endcase
    end
    if (w_push_req && w_full) begin
      w_drop      = 1'b1;
      w_hold_load = 1'b0;
      w_hold_clr  = 1'b1;
      if (!FRAME_START_I && !FRAME_END_I) w_nstate = S_DROP;
    end
  end

  // Hold register delays each pixel by one cycle so its EOL flag is known when pushed
  always_ff @(posedge PARALLEL_CLOCK_I or posedge RESET_I) begin
    if (RESET_I) begin
      r_lv_q        <= 1'b0;
      r_hold_vld    <= 1'b0;
      r_hold_sof    <= 1'b0;
      r_hold_data   <= '0;
      r_sof_pending <= 1'b0;
    end else begin
      r_lv_q <= LINE_VALID_I;
      if (w_hold_load) begin
        r_hold_vld  <= 1'b1;
        r_hold_sof  <= r_sof_pending;
        r_hold_data <= DATA_I;
      end else if (w_hold_clr) begin
        r_hold_vld  <= 1'b0;
      end
      if (w_sof_set)        r_sof_pending <= 1'b1;
      else if (w_hold_load) r_sof_pending <= 1'b0;
    end
  end

  // The output register counts as one FIFO slot; pushes bypass memory when it is free
  assign w_mcount    = r_count - W_CNT'(r_out_vld);
  assign w_mem_empty = (w_mcount == '0);
  assign w_out_load  = !r_out_vld || TREADY_I;
  assign w_pop_mem   = w_out_load && !w_mem_empty;
  assign w_mem_wr    = w_push && !(w_out_load && w_mem_empty);
  assign w_beat      = r_out_vld && TREADY_I;

  always_ff @(posedge PARALLEL_CLOCK_I) begin
    if (w_mem_wr) r_mem[r_wr_ptr] <= w_push_ent;
  end

  always_ff @(posedge PARALLEL_CLOCK_I or posedge RESET_I) begin
    if (RESET_I) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_out_vld <= 1'b0;
      r_out_ent <= '0;
    end else begin
      if (w_mem_wr)  r_wr_ptr <= r_wr_ptr + g_FIFO_AW'(1);
      if (w_pop_mem) r_rd_ptr <= r_rd_ptr + g_FIFO_AW'(1);
      r_count <= r_count + W_CNT'(w_push) - W_CNT'(w_beat);
      if (w_out_load) begin
        if (!w_mem_empty) begin
          r_out_vld <= 1'b1;
          r_out_ent <= r_mem[r_rd_ptr];
        end else if (w_push) begin
          r_out_vld <= 1'b1;
          r_out_ent <= w_push_ent;
        end else begin
          r_out_vld <= 1'b0;
        end
      end
    end
  end

  // Sticky overflow and saturating error counter; CLEAR_I wins
  always_ff @(posedge PARALLEL_CLOCK_I or posedge RESET_I) begin
    if (RESET_I) begin
      r_overflow <= 1'b0;
      r_err_cnt  <= '0;
    end else if (CLEAR_I) begin
      r_overflow <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if ((ECC_ERROR_I || CRC_ERROR_I) && (r_err_cnt != C_SAT)) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign TVALID_O    = r_out_vld;
  assign TUSER_O     = r_out_ent[W_ENT-1];
  assign TLAST_O     = r_out_ent[W_ENT-2];
  assign TDATA_O     = r_out_ent[g_DATAWIDTH-1:0];
  assign OVERFLOW_O  = r_overflow;
  assign ERR_COUNT_O = r_err_cnt;

`ifdef CSI2_FRAME_STATS_EN
  logic [15:0] r_pix_cnt;
  logic [15:0] r_line_cnt;
  logic [15:0] r_width_lat;
  logic        r_width_done;
  logic [15:0] r_line_width;
  logic [15:0] r_frame_height;
  logic        w_act;
  logic [15:0] w_width_now;
  logic [15:0] w_height_now;

  assign w_act        = (r_state == S_ACTIVE);
  assign w_width_now  = r_width_done ? r_width_lat : r_pix_cnt;
  assign w_height_now = (w_fall && (r_line_cnt != C_SAT)) ? r_line_cnt + 16'd1 : r_line_cnt;

  // Geometry counters only run while the frame is intact; results published at frame end
  always_ff @(posedge PARALLEL_CLOCK_I or posedge RESET_I) begin
    if (RESET_I) begin
      r_pix_cnt      <= '0;
      r_line_cnt     <= '0;
      r_width_lat    <= '0;
      r_width_done   <= 1'b0;
      r_line_width   <= '0;
      r_frame_height <= '0;
    end else begin
      if (FRAME_START_I) begin
        r_pix_cnt    <= '0;
        r_line_cnt   <= '0;
        r_width_lat  <= '0;
        r_width_done <= 1'b0;
      end else if (w_act) begin
        if (LINE_VALID_I && !r_width_done && (r_pix_cnt != C_SAT)) r_pix_cnt <= r_pix_cnt + 16'd1;
        if (w_fall) begin
          if (r_line_cnt != C_SAT) r_line_cnt <= r_line_cnt + 16'd1;
          if (!r_width_done) begin
            r_width_lat  <= r_pix_cnt;
            r_width_done <= 1'b1;
          end
        end
        if (FRAME_END_I) begin
          r_line_width   <= w_width_now;
          r_frame_height <= w_height_now;
        end
      end
    end
  end

  assign LINE_WIDTH_O   = r_line_width;
  assign FRAME_HEIGHT_O = r_frame_height;
`else
  assign LINE_WIDTH_O   = '0;
  assign FRAME_HEIGHT_O = '0;
`endif

endmodule

// File: tb/tb_csi2_pixel_axis_adapter.sv
// Self-checking bench: a large-FIFO instance checked beat-by-beat against expected beats derived
// from each frame's description, plus a 4-entry instance for overflow/drop behaviour.
module tb_csi2_pixel_axis_adapter;
  localparam int unsigned DW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          d_fs, d_fe, d_lv, d_ecc, d_crc, d_clr;
  logic [DW-1:0] d_data;
  logic          sel_small;
  logic          tready_fix, tog_en, s_tready;
  logic          tog_val = 1'b0;
  always @(posedge clk) tog_val <= ~tog_val;

  logic          b_fs, b_fe, b_lv, b_ecc, b_crc, b_clr, b_tready;
  logic [DW-1:0] b_data;
  logic          s_fs, s_fe, s_lv, s_ecc, s_crc, s_clr;
  logic [DW-1:0] s_data;

  assign b_fs = sel_small ? 1'b0 : d_fs;
  assign b_fe = sel_small ? 1'b0 : d_fe;
  assign b_lv = sel_small ? 1'b0 : d_lv;
  assign b_ecc = sel_small ? 1'b0 : d_ecc;
  assign b_crc = sel_small ? 1'b0 : d_crc;
  assign b_clr = sel_small ? 1'b0 : d_clr;
  assign b_data = sel_small ? '0 : d_data;
  assign b_tready = tog_en ? tog_val : tready_fix;
  assign s_fs = sel_small ? d_fs : 1'b0;
  assign s_fe = sel_small ? d_fe : 1'b0;
  assign s_lv = sel_small ? d_lv : 1'b0;
  assign s_ecc = sel_small ? d_ecc : 1'b0;
  assign s_crc = sel_small ? d_crc : 1'b0;
  assign s_clr = sel_small ? d_clr : 1'b0;
  assign s_data = sel_small ? d_data : '0;

  logic [DW-1:0] b_tdata, s_tdata;
  logic          b_tvalid, b_tuser, b_tlast, b_ovf;
  logic          s_tvalid, s_tuser, s_tlast, s_ovf;
  logic [15:0]   b_err, b_lw, b_fh, s_err, s_lw, s_fh;

  csi2_pixel_axis_adapter #(.g_DATAWIDTH(DW), .g_FIFO_AW(10)) u_big (
    .PARALLEL_CLOCK_I(clk), .RESET_I(rst), .FRAME_START_I(b_fs), .FRAME_END_I(b_fe),
    .LINE_VALID_I(b_lv), .DATA_I(b_data), .ECC_ERROR_I(b_ecc), .CRC_ERROR_I(b_crc),
    .CLEAR_I(b_clr), .TDATA_O(b_tdata), .TVALID_O(b_tvalid), .TREADY_I(b_tready),
    .TUSER_O(b_tuser), .TLAST_O(b_tlast), .OVERFLOW_O(b_ovf), .ERR_COUNT_O(b_err),
    .LINE_WIDTH_O(b_lw), .FRAME_HEIGHT_O(b_fh));

  csi2_pixel_axis_adapter #(.g_DATAWIDTH(DW), .g_FIFO_AW(2)) u_small (
    .PARALLEL_CLOCK_I(clk), .RESET_I(rst), .FRAME_START_I(s_fs), .FRAME_END_I(s_fe),
    .LINE_VALID_I(s_lv), .DATA_I(s_data), .ECC_ERROR_I(s_ecc), .CRC_ERROR_I(s_crc),
    .CLEAR_I(s_clr), .TDATA_O(s_tdata), .TVALID_O(s_tvalid), .TREADY_I(s_tready),
    .TUSER_O(s_tuser), .TLAST_O(s_tlast), .OVERFLOW_O(s_ovf), .ERR_COUNT_O(s_err),
    .LINE_WIDTH_O(s_lw), .FRAME_HEIGHT_O(s_fh));

  int n_tests = 0;
  int n_fail  = 0;
  int tot_beats = 0, tot_tuser = 0, tot_tlast = 0;
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] s_cap[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Big-instance stream checker: every handshake against the expected beat, payload hold during stalls
  logic          prev_stall = 1'b0;
  logic [DW+1:0] prev_pay;
  always @(negedge clk) begin
    logic [DW+1:0] pay;
    logic [DW+1:0] e;
    pay = {b_tuser, b_tlast, b_tdata};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_tests++;
        if (!b_tvalid || pay !== prev_pay) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%0b pay=0x%0h, expected valid=1 pay=0x%0h", b_tvalid, pay, prev_pay);
        end
      end
      if (b_tvalid && b_tready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: got pay=0x%0h, expected no beat", pay);
        end else begin
          e = exp_q.pop_front();
          if (pay !== e) begin
            n_fail++;
            $display("FAIL beat: got 0x%0h, expected 0x%0h", pay, e);
          end
        end
        tot_beats++;
        if (b_tuser) tot_tuser++;
        if (b_tlast) tot_tlast++;
      end
      prev_stall = b_tvalid && !b_tready;
      prev_pay   = pay;
    end
  end

  always @(negedge clk) begin
    if (!rst && s_tvalid && s_tready) s_cap.push_back({s_tuser, s_tlast, s_tdata});
  end

  // Drives one frame; expected beats follow directly from frame geometry
  task automatic drive_frame(input logic [DW-1:0] first, input int w, input int lines, input bit chk_lat);
    d_fs = 1'b1; tick(); d_fs = 1'b0;
    for (int l = 0; l < lines; l++) begin
      for (int i = 0; i < w; i++) begin
        logic [DW-1:0] px;
        px = first + DW'(l * w + i);
        if (!sel_small) exp_q.push_back({1'((l == 0) && (i == 0)), 1'(i == w - 1), px});
        if (chk_lat && l == 0 && i == 1) check("latency_not_yet", 32'(b_tvalid), 32'd0);
        if (chk_lat && l == 0 && i == 2) check("latency_n_plus_2", 32'(b_tvalid), 32'd1);
        d_lv = 1'b1; d_data = px; tick();
      end
      d_lv = 1'b0; d_data = '0; tick(); tick();
    end
    d_fe = 1'b1; tick(); d_fe = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int k = 0;
    while ((exp_q.size() != 0 || b_tvalid) && k < maxc) begin
      tick();
      k++;
    end
    check(name, 32'(exp_q.size() == 0 && !b_tvalid), 32'd1);
  endtask

  task automatic check_stats(input string name, input logic [15:0] lw, input logic [15:0] fh,
                             input logic [15:0] ew, input logic [15:0] eh);
`ifdef CSI2_FRAME_STATS_EN
    check({name, "_width"}, 32'(lw), 32'(ew));
    check({name, "_height"}, 32'(fh), 32'(eh));
`else
    check({name, "_width"}, 32'(lw), 32'd0);
    check({name, "_height"}, 32'(fh), 32'd0);
    if (ew == 16'hFFFF && eh == 16'hFFFF) $display("stats args unused");
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, u0, l0;
    rst = 1'b1; d_fs = 0; d_fe = 0; d_lv = 0; d_ecc = 0; d_crc = 0; d_clr = 0; d_data = '0;
    sel_small = 1'b0; tready_fix = 1'b1; tog_en = 1'b0; s_tready = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", 32'(b_tvalid), 32'd0);
    check("rst_tdata", 32'(b_tdata), 32'd0);
    check("rst_tuser_tlast", 32'({b_tuser, b_tlast}), 32'd0);
    check("rst_ovf_err", 32'({b_ovf, b_err}), 32'd0);
    check("rst_stats", 32'({b_lw, b_fh}), 32'd0);
    rst = 1'b0;
    tick();

    // 4x3 frame, full throughput
    b0 = tot_beats; u0 = tot_tuser; l0 = tot_tlast;
    drive_frame(10'h001, 4, 3, 1'b1);
    check_stats("frame4x3", b_lw, b_fh, 16'd4, 16'd3);
    wait_drain("drain_4x3", 100);
    check("beats_4x3", 32'(tot_beats - b0), 32'd12);
    check("tuser_4x3", 32'(tot_tuser - u0), 32'd1);
    check("tlast_4x3", 32'(tot_tlast - l0), 32'd3);

    // Pixels outside a frame are discarded
    for (int i = 0; i < 5; i++) begin d_lv = 1'b1; d_data = DW'(i + 'h40); tick(); end
    d_lv = 1'b0;
    for (int i = 0; i < 6; i++) begin check("idle_no_beat", 32'(b_tvalid), 32'd0); tick(); end

    // Alternating ready on a 16-pixel line
    b0 = tot_beats; u0 = tot_tuser; l0 = tot_tlast;
    tog_en = 1'b1;
    drive_frame(10'h101, 16, 1, 1'b0);
    check_stats("frame16x1", b_lw, b_fh, 16'd16, 16'd1);
    wait_drain("drain_toggle", 200);
    tog_en = 1'b0;
    check("beats_toggle", 32'(tot_beats - b0), 32'd16);
    check("tuser_toggle", 32'(tot_tuser - u0), 32'd1);
    check("tlast_toggle", 32'(tot_tlast - l0), 32'd1);

    // Error counter with overlap, then clear
    d_ecc = 1'b1; tick(); tick();
    d_crc = 1'b1; tick();
    d_ecc = 1'b0; tick();
    d_crc = 1'b0; tick();
    check("err_count", 32'(b_err), 32'd4);
    d_clr = 1'b1; tick(); d_clr = 1'b0;
    check("err_clear", 32'(b_err), 32'd0);

    // Small FIFO: good frame, overflowed frame, recovery frame
    sel_small = 1'b1; s_tready = 1'b1;
    drive_frame(10'h051, 2, 2, 1'b0);
    repeat (6) tick();
    check("s_good_count", 32'(s_cap.size()), 32'd4);
    check("s_good_first", 32'(s_cap[0]), 32'({1'b1, 1'b0, 10'h051}));
    check("s_good_eol1", 32'(s_cap[1]), 32'({1'b0, 1'b1, 10'h052}));
    check("s_good_last", 32'(s_cap[3]), 32'({1'b0, 1'b1, 10'h054}));
    check_stats("s_good", s_lw, s_fh, 16'd2, 16'd2);
    check("s_ovf_before", 32'(s_ovf), 32'd0);

    s_tready = 1'b0;
    drive_frame(10'h001, 8, 1, 1'b0);
    check("s_ovf_set", 32'(s_ovf), 32'd1);
    check("s_head_pay", 32'({s_tvalid, s_tuser, s_tlast, s_tdata}), 32'({1'b1, 1'b1, 1'b0, 10'h001}));
    check_stats("s_dropped_keep", s_lw, s_fh, 16'd2, 16'd2);
    s_cap.delete();
    s_tready = 1'b1;
    repeat (8) tick();
    check("s_drain_count", 32'(s_cap.size()), 32'd4);
    check("s_drain_first", 32'(s_cap[0]), 32'({1'b1, 1'b0, 10'h001}));
    check("s_drain_last", 32'(s_cap[3]), 32'({1'b0, 1'b0, 10'h004}));
    drive_frame(10'h0A1, 3, 1, 1'b0);
    repeat (6) tick();
    check("s_recover_count", 32'(s_cap.size()), 32'd7);
    check("s_recover_sof", 32'(s_cap[4]), 32'({1'b1, 1'b0, 10'h0A1}));
    check("s_recover_eol", 32'(s_cap[6]), 32'({1'b0, 1'b1, 10'h0A3}));
    check_stats("s_recover", s_lw, s_fh, 16'd3, 16'd1);
    d_clr = 1'b1; tick(); d_clr = 1'b0;
    check("s_ovf_clear", 32'(s_ovf), 32'd0);
    sel_small = 1'b0;
    tick();

    // Reset mid-line with five beats queued
    tready_fix = 1'b0;
    d_fs = 1'b1; tick(); d_fs = 1'b0;
    for (int i = 0; i < 6; i++) begin d_lv = 1'b1; d_data = DW'('h201 + i); tick(); end
    check("pre_rst_head", 32'({b_tvalid, b_tuser, b_tlast, b_tdata}), 32'({1'b1, 1'b1, 1'b0, 10'h201}));
    d_lv = 1'b0; d_data = '0; rst = 1'b1;
    tick();
    check("midrst_stream", 32'({b_tvalid, b_tuser, b_tlast, b_tdata}), 32'd0);
    check("midrst_status", 32'({b_ovf, b_err}), 32'd0);
    check("midrst_stats", 32'({b_lw, b_fh}), 32'd0);
    rst = 1'b0; exp_q.delete(); tready_fix = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin d_lv = 1'b1; d_data = DW'('h250 + i); tick(); end
    d_lv = 1'b0;
    for (int i = 0; i < 6; i++) begin check("post_rst_no_beat", 32'(b_tvalid), 32'd0); tick(); end
    b0 = tot_beats;
    drive_frame(10'h301, 2, 1, 1'b0);
    wait_drain("drain_post_rst", 100);
    check("beats_post_rst", 32'(tot_beats - b0), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
